// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg
// ----------------
// Back-pressurable register pipeline of DEPTH stages, each WIDTH bits wide,
// with a valid/ready handshake on both sides. Stage 0 is the input side and
// stage DEPTH-1 drives the outputs. Empty stages always accept a beat, even
// while downstream stalls, so bubbles collapse without costing throughput.
//
// Ports:
//   i_clk     clock, all state updates on posedge
//   i_arst_n  asynchronous reset, active-low
//   i_srst    synchronous clear, active-high (discards beats in flight)
//   i_valid   upstream data valid
//   i_data    upstream data, WIDTH bits
//   o_ready   pipeline can accept i_data this cycle (combinational from i_ready)
//   o_valid   stage DEPTH-1 holds valid data (direct from flop)
//   o_data    data of stage DEPTH-1 (direct from flop)
//   i_ready   downstream accepts o_data this cycle
//   o_count   number of valid stages, 0..DEPTH (derived from flops only)

module elastic_pipe_reg #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               DATA_RESET = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic                       i_srst,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_depth_check
    $error("elastic_pipe_reg: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_width_check
    $error("elastic_pipe_reg: WIDTH must be >= 1");
  end

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r     [DEPTH];
  logic [DEPTH-1:0] en_s;
  logic [DEPTH-1:0] in_valid_s;
  logic [WIDTH-1:0] in_data_s  [DEPTH];
  logic [CW-1:0]    count_s;

  // Stage enables: a stage may load when it is empty or everything below it
  // will move. Built as a running OR from the output side so no vector bit
  // depends on another bit of the same vector.
  always_comb begin
    logic acc_s;
    en_s  = '0;
    acc_s = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc_s   = acc_s | ~valid_r[k];
      en_s[k] = acc_s;
    end
  end

  // Incoming valid/data seen by each stage: upstream for stage 0, else the
  // stage on the input side of it.
  always_comb begin
    in_valid_s[0] = i_valid;
    in_data_s[0]  = i_data;
    for (int k = 1; k < DEPTH; k++) begin
      in_valid_s[k] = valid_r[k-1];
      in_data_s[k]  = data_r[k-1];
    end
  end

  // Valid bits: always reset, cleared by i_srst, otherwise shift on enable.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      valid_r <= '0;
    end else if (i_srst) begin
      valid_r <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (en_s[k]) begin
          valid_r[k] <= in_valid_s[k];
        end
      end
    end
  end

  if (DATA_RESET) begin : g_data_rst
    // Data registers with reset/clear to RESET_VAL; load only real beats so
    // a bubble passing through leaves the previous data in place.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        for (int k = 0; k < DEPTH; k++) data_r[k] <= RESET_VAL;
      end else if (i_srst) begin
        for (int k = 0; k < DEPTH; k++) data_r[k] <= RESET_VAL;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (en_s[k] && in_valid_s[k]) begin
            data_r[k] <= in_data_s[k];
          end
        end
      end
    end
  end else begin : g_data_norst
    // Data registers without reset; i_srst only drops valids, data holds.
    always_ff @(posedge i_clk) begin
      if (!i_srst) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (en_s[k] && in_valid_s[k]) begin
            data_r[k] <= in_data_s[k];
          end
        end
      end
    end
  end

  // Occupancy: popcount of the valid flops, no input dependence.
  always_comb begin
    count_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_s = count_s + CW'(valid_r[k]);
    end
  end

  assign o_ready = en_s[0] & ~i_srst;
  assign o_valid = valid_r[DEPTH-1];
  assign o_data  = data_r[DEPTH-1];
  assign o_count = count_s;

endmodule
